// File: rtl/ex_alu_if.sv
// Handshake and operand/result bundle between the EX pipeline and the ALU.
// master = pipeline side, slave = ALU side.
interface ex_alu_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic            out_valid;
  logic [XLEN-1:0] alu_result;
  logic            alu_bcond;
  logic            busy;

  modport master (
    output flush, in_valid, alu_ctrl, alu_in_1, alu_in_2,
    input  in_ready, out_valid, alu_result, alu_bcond, busy
  );

  modport slave (
    input  flush, in_valid, alu_ctrl, alu_in_1, alu_in_2,
    output in_ready, out_valid, alu_result, alu_bcond, busy
  );
endinterface

// File: rtl/ex_alu_iterative.sv
// EX-stage ALU: single-cycle arithmetic/logic/compare, iterative SLL/SRL
// shifting SHIFT_STEP bits per cycle. Op codes: ADD=0 SUB=1 SLL=2 SRL=3
// XOR=4 OR=5 AND=6 BEQ=8 BNE=9 BLT=10 BGE=11; other codes are undefined.
//
//  state | meaning
//  IDLE  | ready to accept; single-cycle ops complete from here
//  SHIFT | iterative shift in progress, in_ready low
module ex_alu_iterative #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic   clk,
  input  logic   reset,
  ex_alu_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_SRL = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_BEQ = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;
  localparam logic [3:0] ALU_BLT = 4'd10;
  localparam logic [3:0] ALU_BGE = 4'd11;

  localparam logic [4:0] STEP_K = 5'(SHIFT_STEP);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] acc;
  logic [4:0]      cnt;
  logic            dir_right;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            bcond_q;

  logic            accept;
  logic            is_shift;
  logic [4:0]      shamt;
  logic            start_shift;
  logic [XLEN-1:0] op_result;
  logic            op_bcond;
  logic [4:0]      step_k;
  logic [XLEN-1:0] acc_shifted;
  logic            shift_done;

  always_comb begin
    state_next  = state;
    accept      = bus.in_valid && (state == IDLE) && !bus.flush;
    shamt       = bus.alu_in_2[4:0];
    is_shift    = (bus.alu_ctrl == ALU_SLL) || (bus.alu_ctrl == ALU_SRL);
    start_shift = accept && is_shift && (shamt != 5'd0);
    step_k      = (cnt > STEP_K) ? STEP_K : cnt;
    acc_shifted = dir_right ? (acc >> step_k) : (acc << step_k);
    shift_done  = (state == SHIFT) && !bus.flush && (cnt == step_k);
    op_result   = '0;
    op_bcond    = 1'b0;

    unique case (bus.alu_ctrl)
      ALU_ADD: op_result = bus.alu_in_1 + bus.alu_in_2;
      ALU_SUB: op_result = bus.alu_in_1 - bus.alu_in_2;
      // only reached with shamt==0; nonzero amounts go through SHIFT
      ALU_SLL, ALU_SRL: op_result = bus.alu_in_1;
      ALU_XOR: op_result = bus.alu_in_1 ^ bus.alu_in_2;
      ALU_OR:  op_result = bus.alu_in_1 | bus.alu_in_2;
      ALU_AND: op_result = bus.alu_in_1 & bus.alu_in_2;
      ALU_BEQ: begin
        op_result = bus.alu_in_1 - bus.alu_in_2;
        op_bcond  = (bus.alu_in_1 == bus.alu_in_2);
      end
      ALU_BNE: begin
        op_result = bus.alu_in_1 - bus.alu_in_2;
        op_bcond  = (bus.alu_in_1 != bus.alu_in_2);
      end
      ALU_BLT: begin
        op_result = bus.alu_in_1 - bus.alu_in_2;
        op_bcond  = ($signed(bus.alu_in_1) < $signed(bus.alu_in_2));
      end
      ALU_BGE: begin
        op_result = bus.alu_in_1 - bus.alu_in_2;
        op_bcond  = ($signed(bus.alu_in_1) >= $signed(bus.alu_in_2));
      end
      default: ;
    endcase

    unique case (state)
      IDLE:  if (start_shift) state_next = SHIFT;
      SHIFT: if (bus.flush || shift_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      dir_right   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      bcond_q     <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid_q <= 1'b0;
      if (start_shift) begin
        acc       <= bus.alu_in_1;
        cnt       <= shamt;
        dir_right <= (bus.alu_ctrl == ALU_SRL);
      end else if (accept) begin
        result_q    <= op_result;
        bcond_q     <= op_bcond;
        out_valid_q <= 1'b1;
      end
      if (state == SHIFT) begin
        if (bus.flush) begin
          cnt <= '0;
        end else begin
          acc <= acc_shifted;
          cnt <= cnt - step_k;
          if (shift_done) begin
            result_q    <= acc_shifted;
            bcond_q     <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state == SHIFT);
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.alu_bcond  = bcond_q;

endmodule

// File: tb/tb_ex_alu_iterative.sv
// Scoreboard bench for ex_alu_iterative: driver pushes reference results,
// a negedge monitor pops and checks value, bcond and completion cycle.
module tb_ex_alu_iterative;
  localparam int STEP = 1;

  localparam logic [3:0] C_ADD = 4'd0;
  localparam logic [3:0] C_SUB = 4'd1;
  localparam logic [3:0] C_SLL = 4'd2;
  localparam logic [3:0] C_SRL = 4'd3;
  localparam logic [3:0] C_BEQ = 4'd8;
  localparam logic [3:0] C_BLT = 4'd10;
  localparam logic [3:0] C_BGE = 4'd11;

  typedef struct {
    logic [31:0] res;
    logic        bc;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  ex_alu_if #(.XLEN(32)) bus();

  ex_alu_iterative #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  exp_t        q[$];
  logic [31:0] last_res = '0;
  logic        last_bc  = 1'b0;
  logic [31:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the op definitions, not from the RTL structure.
  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic bc, output int lat);
    int sh;
    sh  = int'(b % 32);
    res = 32'd0;
    bc  = 1'b0;
    lat = 1;
    case (c)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: begin res = a * (32'd1 << sh); if (sh != 0) lat = (sh + STEP - 1) / STEP + 1; end
      4'd3: begin res = a / (32'd1 << sh); if (sh != 0) lat = (sh + STEP - 1) / STEP + 1; end
      4'd4: res = a ^ b;
      4'd5: res = a | b;
      4'd6: res = a & b;
      4'd8: begin res = a - b; bc = (a == b); end
      4'd9: begin res = a - b; bc = (a != b); end
      4'd10: begin res = a - b; bc = (int'(a) < int'(b)); end
      4'd11: begin res = a - b; bc = (int'(a) >= int'(b)); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_res = '0;
      last_bc  = 1'b0;
    end else begin
      chk("busy_vs_ready", 32'(bus.busy), 32'(!bus.in_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", bus.alu_result, e.res);
          chk("bcond", 32'(bus.alu_bcond), 32'(e.bc));
          chk("latency_cycle", 32'(cyc), 32'(e.due));
        end
        last_res = bus.alu_result;
        last_bc  = bus.alu_bcond;
      end else begin
        chk("hold_result", bus.alu_result, last_res);
        chk("hold_bcond", 32'(bus.alu_bcond), 32'(last_bc));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t        e;
    logic [31:0] r;
    logic        bc;
    int          lat;
    int          w;
    w = 0;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.alu_ctrl = c;
    bus.alu_in_1 = a;
    bus.alu_in_2 = b;
    bus.in_valid = 1'b1;
    if (push) begin
      model(c, a, b, r, bc, lat);
      e.res = r;
      e.bc  = bc;
      e.due = cyc + lat;
      q.push_back(e);
      last_exp = r;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || !bus.in_ready) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a, b;
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = '0;
    bus.alu_in_1 = '0;
    bus.alu_in_2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.alu_result, 32'd0);
    chk("rst_bcond", 32'(bus.alu_bcond), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    send(C_ADD, 32'd7, 32'd5, 1);
    send(C_SUB, 32'd3, 32'd5, 1);
    send(C_BLT, 32'hFFFF_FFFF, 32'd1, 1);
    send(C_BGE, 32'hFFFF_FFFF, 32'd1, 1);
    send(C_BEQ, 32'd4, 32'd4, 1);
    drain();

    send(C_SLL, 32'd1, 32'd31, 1);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sll31_ready_low_cycles", 32'(n), 32'((31 + STEP - 1) / STEP));
    drain();

    send(C_SRL, 32'h8000_0000, 32'd0, 1);
    chk("srl0_busy", 32'(bus.busy), 32'd0);
    chk("srl0_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    send(C_SLL, 32'h0000_1234, 32'd10, 0);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_result_kept", bus.alu_result, last_exp);
    repeat (15) @(negedge clk);

    send(C_SRL, 32'hF000_0000, 32'd10, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_mid_result", bus.alu_result, 32'd0);
    repeat (15) @(negedge clk);

    bus.alu_ctrl = C_ADD;
    bus.alu_in_1 = 32'd100;
    bus.alu_in_2 = 32'd200;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    send(C_ADD, 32'd10, 32'd20, 1);
    drain();

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      if ($urandom_range(0, 5) == 0) b = a;
      send(4'($urandom_range(0, 15)), a, b, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
